layer_result_collector: RTL and testbench
=========================================

# layer_result_collector

Downstream consumer of the fully-connected layer engine's per-neuron output stream (`neuron_done` / `neuron_out`). It applies an optional ReLU to each neuron result and stores the OUT results of one layer in a register buffer. It tracks the running maximum and its index, then presents the layer's argmax classification on a valid/ready handshake. The buffer is also exposed through an asynchronous read port for inspection or chaining into the next layer.

## Interface
- `DWIDTH`, 32, neuron value width; signed two's complement fixed point.
- `FRACTIONAL`, 21, fractional bits of `neuron_out`; used only to define 1.0 in tests, no rescaling.
- `OUT`, 2, neurons per layer, ≥ 1.
- `RELU_EN`, 1, 1 clamps negative neuron values to 0 before storage and compare; 0 passes them through.
- `IDX_W`, derived as max(1, $clog2(OUT)); not overridable.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `neuron_done`  in  1  one-cycle strobe; `neuron_out` is valid this cycle.
- `neuron_out`  in  DWIDTH  signed neuron result.
- `result_valid`  out  1  argmax result available.
- `result_ready`  in  1  consumer accepts the result.
- `result_idx`  out  IDX_W  index of the maximum neuron.
- `result_max`  out  DWIDTH  value of the maximum neuron, post-ReLU.
- `rd_addr`  in  IDX_W  buffer read address.
- `rd_data`  out  DWIDTH  buffer entry at `rd_addr`, combinational; 0 if `rd_addr` ≥ OUT.
- `count`  out  IDX_W+1  neurons captured in the current layer.
- `overrun`  out  1  sticky flag: a strobe was dropped while a result was pending.

## Operation
- FSM states: COLLECT and RESULT.
  - Reset state is COLLECT.
- In COLLECT, each `neuron_done` does the following:
  - v = (RELU_EN and `neuron_out` < 0) ? 0 : `neuron_out`.
  - `buf[count]` ← v.
  - `count`++.
  - Max update: if `count` == 0, then max ← v and idx ← 0. Else if v > max (signed, strict), then max ← v and idx ← `count`.
  - Ties keep the lower index.
- When the captured strobe is the OUT-th one, the FSM moves to RESULT.
  - At that transition, `count` holds OUT and `result_valid` goes to 1.
- In RESULT:
  - `result_idx` and `result_max` are held stable.
  - `neuron_done` is dropped: buffer, max and count are unchanged, and `overrun` is set.
- Handshake `result_valid` & `result_ready` at an edge:
  - FSM returns to COLLECT.
  - `count` ← 0.
  - `result_valid` ← 0.
- Handshake and `neuron_done` in the same cycle: the strobe is accepted as index 0 of the next layer.
  - `count` ← 1.
  - max ← v, idx ← 0.
  - No overrun.
- The buffer is not cleared between layers; entries are overwritten in order.
- `rd_data` reflects writes from the edge after the write.
- `overrun` is cleared only by reset.
- `result_ready` is ignored while `result_valid` = 0.

## Timing
- Reset values:
  - `result_valid` = 0, `result_idx` = 0, `result_max` = 0.
  - `count` = 0, `overrun` = 0.
  - All buffer entries = 0, state = COLLECT.
- Capture latency: 1 cycle (`neuron_done` at edge n; buffer and `count` updated after edge n).
- Result latency: `result_valid` is high in the cycle after the edge sampling the OUT-th `neuron_done`.
- Throughput: a strobe is accepted every cycle in COLLECT.
  - A back-to-back strobe in the cycle `result_valid` rises is dropped unless `result_ready` is high.
- OUT = 1: every strobe produces a result, with `result_idx` = 0.
- Reset mid-layer or mid-result: immediate return to the reset values; the partial layer is discarded.

## Structure
- Shared package `nn_pkg`:
  - state enum `collect_state_t` {COLLECT, RESULT}.
  - `fx_t` signed [DWIDTH-1:0] typedef.
  - helper function `fx_one(FRACTIONAL)`.
- Sub-module `relu_unit` (combinational, parameter `RELU_EN`): `neuron_out` → v.
  - Reusable by the next layer's input path.
- The buffer is a flat register array `buf[OUT]`, not a RAM, because it needs the asynchronous read port.

## Test plan
- **Basic argmax** (OUT=2, RELU_EN=1): strobes 0x0020_0000 (1.0), then 0x0040_0000 (2.0) → `result_valid` 1 cycle after the 2nd strobe; `result_idx` = 1, `result_max` = 0x0040_0000; `rd_data`[0] = 0x0020_0000.
- **ReLU and tie** (OUT=2): strobes 0xFFE0_0000 (−1.0), then 0x0000_0000 → both stored as 0; `result_idx` = 0, `result_max` = 0. Same with RELU_EN=0 → `result_idx` = 1, `rd_data`[0] = 0xFFE0_0000.
- **Backpressure** (OUT=2): hold `result_ready` = 0 for 5 cycles while sending 1 extra strobe → result held stable, `overrun` = 1, `count` stays 2. Then raise `result_ready` → `result_valid` = 0, `count` = 0.
- **Simultaneous handshake and strobe**: `result_ready` = 1 together with strobe 0x0060_0000 → `count` = 1, no overrun. After the next strobe 0x0010_0000 → `result_idx` = 0, `result_max` = 0x0060_0000.
- **Reset mid-layer**: 1 strobe, assert `nreset` low asynchronously between edges → all outputs and `rd_data` read 0 immediately; the next full layer produces a correct result.
- **OUT=1 stream**: 3 consecutive strobes with `result_ready` tied 1 → `result_valid` pulses after each, `result_idx` = 0, `overrun` = 0.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: types and helpers shared by the neural-network datapath blocks.
//   collect_state_t : state of the layer result collector FSM
//   fx_t            : signed fixed-point neuron value
//   fx_one()        : fixed-point encoding of 1.0 for a given fractional width
package nn_pkg;

    localparam int DWIDTH     = 32;
    localparam int FRACTIONAL = 21;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } collect_state_t;

    typedef logic signed [DWIDTH-1:0] fx_t;

    function automatic fx_t fx_one(input int frac);
        fx_t one;
        one = fx_t'(1);
        return one <<< frac;
    endfunction

endpackage

// File: rtl/layer_result_collector_if.sv
// layer_result_collector_if: bundles the neuron stream, the argmax result
// handshake and the buffer inspection port of one layer result collector.
//   neuron_done/neuron_out : per-neuron strobe and value from the layer engine
//   result_valid/ready     : argmax result handshake, with result_idx/result_max
//   rd_addr/rd_data        : asynchronous buffer read port
//   count/overrun          : capture count and sticky dropped-strobe flag
// modport master = the environment side, modport slave = the collector.
interface layer_result_collector_if #(
    parameter int DWIDTH = 32,
    parameter int OUT    = 2
);
    localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1;

    logic                     neuron_done;
    logic signed [DWIDTH-1:0] neuron_out;
    logic                     result_valid;
    logic                     result_ready;
    logic [IDX_W-1:0]         result_idx;
    logic signed [DWIDTH-1:0] result_max;
    logic [IDX_W-1:0]         rd_addr;
    logic signed [DWIDTH-1:0] rd_data;
    logic [IDX_W:0]           count;
    logic                     overrun;

    modport master (
        output neuron_done, neuron_out, result_ready, rd_addr,
        input  result_valid, result_idx, result_max, rd_data, count, overrun
    );

    modport slave (
        input  neuron_done, neuron_out, result_ready, rd_addr,
        output result_valid, result_idx, result_max, rd_data, count, overrun
    );

endinterface

// File: rtl/layer_result_collector_relu.sv
// relu_unit: combinational optional ReLU applied to a neuron value.
//   neuron_out : signed neuron value in
//   relu_out   : neuron_out, or 0 when RELU_EN is set and the value is negative
module relu_unit #(
    parameter int DWIDTH  = 32,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [DWIDTH-1:0] neuron_out,
    output logic signed [DWIDTH-1:0] relu_out
);

    always_comb begin
        relu_out = neuron_out;
        if (RELU_EN && neuron_out[DWIDTH-1]) begin
            relu_out = '0;
        end
    end

endmodule

// File: rtl/layer_result_collector.sv
// layer_result_collector: captures the OUT neuron results of one layer into a
// register buffer (after optional ReLU), tracks the running maximum and its
// index, and offers the argmax on a valid/ready handshake.
//   clk, nreset : rising-edge clock, asynchronous active-low reset
//   bus (slave) : neuron stream in, argmax result out, buffer read port,
//                 capture count and sticky overrun flag
module layer_result_collector
    import nn_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int FRACTIONAL = 21,
    parameter int OUT        = 2,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     nreset,
    layer_result_collector_if.slave  bus
);

    localparam int             IDX_W   = (OUT > 1) ? $clog2(OUT) : 1;
    localparam logic [IDX_W:0] OUT_CNT = (IDX_W + 1)'(OUT);
    localparam bit             SINGLE  = (OUT == 1);

    if (OUT < 1 || FRACTIONAL >= DWIDTH) begin : g_param_check
        $error("layer_result_collector: OUT must be >= 1 and FRACTIONAL < DWIDTH");
    end

    collect_state_t           state_q, state_d;
    logic [IDX_W:0]           count_q, count_d;
    logic signed [DWIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     overrun_q, overrun_d;
    logic                     wr_en;
    logic [IDX_W-1:0]         wr_addr;
    logic signed [DWIDTH-1:0] v;
    logic signed [DWIDTH-1:0] buf_q [OUT];

    relu_unit #(
        .DWIDTH  (DWIDTH),
        .RELU_EN (RELU_EN)
    ) u_relu (
        .neuron_out (bus.neuron_out),
        .relu_out   (v)
    );

    // Next-state logic. While a result is pending, strobes are dropped and
    // flagged, except in the cycle the result is consumed: that strobe opens
    // the next layer at index 0.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_d     = max_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_addr   = count_q[IDX_W-1:0];
        unique case (state_q)
            COLLECT: begin
                if (bus.neuron_done) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    // Strict compare so ties keep the lower index.
                    if (count_q == '0 || v > max_q) begin
                        max_d = v;
                        idx_d = count_q[IDX_W-1:0];
                    end
                    if (count_d == OUT_CNT) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (bus.result_ready) begin
                    state_d = COLLECT;
                    count_d = '0;
                    if (bus.neuron_done) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = (IDX_W + 1)'(1);
                        max_d   = v;
                        idx_d   = '0;
                        // A single-neuron layer is complete on its first strobe.
                        if (SINGLE) begin
                            state_d = RESULT;
                        end
                    end
                end else if (bus.neuron_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Control and running-maximum registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Flat register buffer so it can be read asynchronously; entries are
    // overwritten in order by each layer and never bulk-cleared except by reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < OUT; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en) begin
            buf_q[wr_addr] <= v;
        end
    end

    // Out-of-range read addresses (OUT not a power of two) return 0.
    always_comb begin
        bus.rd_data = '0;
        if ({1'b0, bus.rd_addr} < OUT_CNT) begin
            bus.rd_data = buf_q[bus.rd_addr];
        end
    end

    assign bus.result_valid = (state_q == RESULT);
    assign bus.result_idx   = idx_q;
    assign bus.result_max   = max_q;
    assign bus.count        = count_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_layer_result_collector.sv
// tb_layer_result_collector: directed scoreboard bench. Three collectors share
// one neuron stream: dut0 (OUT=2, ReLU on), dut2 (OUT=2, ReLU off, same
// result_ready as dut0) and dut1 (OUT=1, ReLU on, result_ready tied high).
// Expected argmax results are queued when a layer is issued and popped by
// per-DUT monitors whenever a result is handshaken.
module tb_layer_result_collector;
    import nn_pkg::*;

    typedef struct {
        int          idx;
        logic [31:0] max;
    } exp_t;

    logic clk;
    logic nreset;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [31:0] one_fx;

    layer_result_collector_if #(.DWIDTH(32), .OUT(2)) bus0();
    layer_result_collector_if #(.DWIDTH(32), .OUT(1)) bus1();
    layer_result_collector_if #(.DWIDTH(32), .OUT(2)) bus2();

    layer_result_collector #(.DWIDTH(32), .FRACTIONAL(21), .OUT(2), .RELU_EN(1'b1)) dut0 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus0)
    );

    layer_result_collector #(.DWIDTH(32), .FRACTIONAL(21), .OUT(1), .RELU_EN(1'b1)) dut1 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus1)
    );

    layer_result_collector #(.DWIDTH(32), .FRACTIONAL(21), .OUT(2), .RELU_EN(1'b0)) dut2 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus2)
    );

    assign bus1.neuron_done  = bus0.neuron_done;
    assign bus1.neuron_out   = bus0.neuron_out;
    assign bus1.result_ready = 1'b1;
    assign bus1.rd_addr      = 1'b0;
    assign bus2.neuron_done  = bus0.neuron_done;
    assign bus2.neuron_out   = bus0.neuron_out;
    assign bus2.result_ready = bus0.result_ready;
    assign bus2.rd_addr      = bus0.rd_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; exp1 is the single-neuron collector's expected result.
    task automatic applyStimulus(input logic [31:0] val, input logic ready, input logic [31:0] exp1);
        bus0.neuron_done  = 1'b1;
        bus0.neuron_out   = val;
        bus0.result_ready = ready;
        q1.push_back('{0, exp1});
        tick();
        bus0.neuron_done  = 1'b0;
        bus0.result_ready = 1'b0;
    endtask

    task automatic handshake();
        bus0.result_ready = 1'b1;
        tick();
        bus0.result_ready = 1'b0;
    endtask

    task automatic expectLayer(input int i0, input logic [31:0] m0, input int i2, input logic [31:0] m2);
        q0.push_back('{i0, m0});
        q2.push_back('{i2, m2});
    endtask

    task automatic readBuf(input logic addr, input logic [31:0] exp0, input logic [31:0] exp2, input string name);
        bus0.rd_addr = addr;
        #1;
        checkOutput({name, " dut0 rd_data"}, bus0.rd_data, exp0);
        checkOutput({name, " dut2 rd_data"}, bus2.rd_data, exp2);
    endtask

    // Scoreboard monitors: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (nreset && bus0.result_valid && bus0.result_ready) begin
            if (q0.size() == 0) begin
                checkOutput("sb0 result pending", 32'(q0.size()), 32'd1);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkOutput("sb0 result_idx", 32'(bus0.result_idx), 32'(e.idx));
                checkOutput("sb0 result_max", bus0.result_max, e.max);
            end
        end
    end

    always @(negedge clk) begin
        if (nreset && bus1.result_valid && bus1.result_ready) begin
            if (q1.size() == 0) begin
                checkOutput("sb1 result pending", 32'(q1.size()), 32'd1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkOutput("sb1 result_idx", 32'(bus1.result_idx), 32'(e.idx));
                checkOutput("sb1 result_max", bus1.result_max, e.max);
            end
        end
    end

    always @(negedge clk) begin
        if (nreset && bus2.result_valid && bus2.result_ready) begin
            if (q2.size() == 0) begin
                checkOutput("sb2 result pending", 32'(q2.size()), 32'd1);
            end else begin
                exp_t e;
                e = q2.pop_front();
                checkOutput("sb2 result_idx", 32'(bus2.result_idx), 32'(e.idx));
                checkOutput("sb2 result_max", bus2.result_max, e.max);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        one_fx = fx_one(FRACTIONAL);
        nreset            = 1'b0;
        bus0.neuron_done  = 1'b0;
        bus0.neuron_out   = '0;
        bus0.result_ready = 1'b0;
        bus0.rd_addr      = 1'b0;

        // Reset values
        #12;
        checkOutput("reset result_valid", 32'(bus0.result_valid), 32'd0);
        checkOutput("reset result_idx", 32'(bus0.result_idx), 32'd0);
        checkOutput("reset result_max", bus0.result_max, 32'd0);
        checkOutput("reset count", 32'(bus0.count), 32'd0);
        checkOutput("reset overrun", 32'(bus0.overrun), 32'd0);
        readBuf(1'b1, 32'd0, 32'd0, "reset buf1");
        readBuf(1'b0, 32'd0, 32'd0, "reset buf0");
        tick();
        nreset = 1'b1;
        tick();

        // Basic argmax
        $display("[TB] basic argmax");
        expectLayer(1, 32'h0040_0000, 1, 32'h0040_0000);
        applyStimulus(one_fx, 1'b0, 32'h0020_0000);
        checkOutput("basic count after 1st", 32'(bus0.count), 32'd1);
        checkOutput("basic valid after 1st", 32'(bus0.result_valid), 32'd0);
        applyStimulus(32'h0040_0000, 1'b0, 32'h0040_0000);
        checkOutput("basic result_valid", 32'(bus0.result_valid), 32'd1);
        checkOutput("basic count", 32'(bus0.count), 32'd2);
        readBuf(1'b0, 32'h0020_0000, 32'h0020_0000, "basic buf0");
        readBuf(1'b1, 32'h0040_0000, 32'h0040_0000, "basic buf1");
        handshake();
        checkOutput("basic valid after hs", 32'(bus0.result_valid), 32'd0);
        checkOutput("basic count after hs", 32'(bus0.count), 32'd0);

        // ReLU and tie: dut0 clamps both to 0 (tie keeps idx 0), dut2 keeps -1.0
        $display("[TB] relu and tie");
        expectLayer(0, 32'h0000_0000, 1, 32'h0000_0000);
        applyStimulus(32'hFFE0_0000, 1'b0, 32'h0000_0000);
        applyStimulus(32'h0000_0000, 1'b0, 32'h0000_0000);
        checkOutput("relu result_valid", 32'(bus0.result_valid), 32'd1);
        readBuf(1'b0, 32'h0000_0000, 32'hFFE0_0000, "relu buf0");
        handshake();

        // Simultaneous handshake and strobe
        $display("[TB] simultaneous handshake and strobe");
        expectLayer(0, 32'h0008_0000, 0, 32'h0008_0000);
        applyStimulus(32'h0008_0000, 1'b0, 32'h0008_0000);
        applyStimulus(32'h0004_0000, 1'b0, 32'h0004_0000);
        expectLayer(0, 32'h0060_0000, 0, 32'h0060_0000);
        applyStimulus(32'h0060_0000, 1'b1, 32'h0060_0000);
        checkOutput("simul count", 32'(bus0.count), 32'd1);
        checkOutput("simul valid", 32'(bus0.result_valid), 32'd0);
        checkOutput("simul overrun", 32'(bus0.overrun), 32'd0);
        checkOutput("simul dut2 count", 32'(bus2.count), 32'd1);
        applyStimulus(32'h0010_0000, 1'b0, 32'h0010_0000);
        checkOutput("simul result_valid", 32'(bus0.result_valid), 32'd1);
        readBuf(1'b0, 32'h0060_0000, 32'h0060_0000, "simul buf0");
        handshake();

        // Backpressure with a dropped strobe
        $display("[TB] backpressure");
        expectLayer(0, 32'h0030_0000, 0, 32'h0030_0000);
        applyStimulus(32'h0030_0000, 1'b0, 32'h0030_0000);
        applyStimulus(32'h0010_0000, 1'b0, 32'h0010_0000);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                applyStimulus(32'h0070_0000, 1'b0, 32'h0070_0000);
            end else begin
                tick();
            end
            checkOutput("bp result_valid", 32'(bus0.result_valid), 32'd1);
            checkOutput("bp result_idx", 32'(bus0.result_idx), 32'd0);
            checkOutput("bp result_max", bus0.result_max, 32'h0030_0000);
            checkOutput("bp count", 32'(bus0.count), 32'd2);
        end
        checkOutput("bp overrun", 32'(bus0.overrun), 32'd1);
        checkOutput("bp dut2 overrun", 32'(bus2.overrun), 32'd1);
        readBuf(1'b0, 32'h0030_0000, 32'h0030_0000, "bp buf0");
        readBuf(1'b1, 32'h0010_0000, 32'h0010_0000, "bp buf1");
        handshake();
        checkOutput("bp valid after hs", 32'(bus0.result_valid), 32'd0);
        checkOutput("bp count after hs", 32'(bus0.count), 32'd0);
        checkOutput("bp overrun sticky", 32'(bus0.overrun), 32'd1);

        // Reset mid-layer, asserted between edges
        $display("[TB] reset mid-layer");
        applyStimulus(32'h0020_0000, 1'b0, 32'h0020_0000);
        checkOutput("rst count before", 32'(bus0.count), 32'd1);
        #2;
        nreset = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        checkOutput("rst result_valid", 32'(bus0.result_valid), 32'd0);
        checkOutput("rst count", 32'(bus0.count), 32'd0);
        checkOutput("rst overrun", 32'(bus0.overrun), 32'd0);
        checkOutput("rst result_max", bus0.result_max, 32'd0);
        checkOutput("rst dut1 valid", 32'(bus1.result_valid), 32'd0);
        readBuf(1'b0, 32'd0, 32'd0, "rst buf0");
        tick();
        nreset = 1'b1;
        tick();
        expectLayer(1, 32'h0050_0000, 1, 32'h0050_0000);
        applyStimulus(32'h0010_0000, 1'b0, 32'h0010_0000);
        applyStimulus(32'h0050_0000, 1'b0, 32'h0050_0000);
        checkOutput("post-rst result_valid", 32'(bus0.result_valid), 32'd1);
        handshake();
        tick();
        tick();

        // Everything issued must have been consumed
        checkOutput("sb0 drained", 32'(q0.size()), 32'd0);
        checkOutput("sb1 drained", 32'(q1.size()), 32'd0);
        checkOutput("sb2 drained", 32'(q2.size()), 32'd0);
        checkOutput("out1 overrun", 32'(bus1.overrun), 32'd0);
        checkOutput("out1 valid idle", 32'(bus1.result_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
